// File: rtl/tone_gen_mc.sv
// Multi-channel square-wave tone generator with ramped envelopes and a
// saturating mixer. Each channel is a tone_gen_ch instance. The envelope
// prescaler and the volume table are shared by all channels.

module tone_gen_ch #(
   parameter int               DIV_W    = 22,
   parameter int               AUD_W    = 16,
   parameter logic [AUD_W-1:0] ENV_STEP = 16'h0040
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             tick_i,
   input  logic [AUD_W-1:0] amp_i,
   output logic [AUD_W-1:0] sample_o,
   output logic             busy_o
);
   logic [DIV_W-1:0] cnt_q, cnt_d, div_lat_q, div_lat_d;
   logic             phase_q, phase_d;
   logic [AUD_W-1:0] env_q, env_d, sample_q, sample_d;
   logic [AUD_W-1:0] target, diff;
   logic             active, up;

   // A divider of 0 or 1 gives no usable tone, so the channel is muted
   assign active = en_i && (div_lat_q > DIV_W'(1));
   assign target = active ? amp_i : '0;
   assign up     = (env_q < target);
   assign diff   = up ? (target - env_q) : (env_q - target);
   assign busy_o = (env_q != target);

   // Half-period counter; the new divider is latched only at wrap so a note change never shortens a half-period
   always_comb begin
      cnt_d     = cnt_q + DIV_W'(1);
      phase_d   = phase_q;
      div_lat_d = div_lat_q;
      if (cnt_q == div_lat_q) begin
         cnt_d     = '0;
         phase_d   = ~phase_q;
         div_lat_d = div_i;
      end
   end

   // Envelope slews toward target by at most ENV_STEP per tick and lands exactly on it
   always_comb begin
      env_d = env_q;
      if (tick_i && (diff != '0)) begin
         if (diff > ENV_STEP) env_d = up ? (env_q + ENV_STEP) : (env_q - ENV_STEP);
         else                 env_d = target;
      end
   end

   // Negative half-wave is the two's complement of env, so env==0 yields a clean 0
   assign sample_d = phase_q ? ('0 - env_q) : env_q;

   // Channel state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         phase_q   <= 1'b0;
         div_lat_q <= DIV_W'(1);
         env_q     <= '0;
         sample_q  <= '0;
      end else begin
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         div_lat_q <= div_lat_d;
         env_q     <= env_d;
         sample_q  <= sample_d;
      end
   end

   assign sample_o = sample_q;
endmodule

module tone_gen_mc #(
   parameter int               NCH      = 2,
   parameter int               DIV_W    = 22,
   parameter int               AUD_W    = 16,
   parameter int               ENV_DIV  = 256,
   parameter logic [AUD_W-1:0] ENV_STEP = 16'h0040
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           volume,
   input  logic [NCH-1:0]       ch_en,
   input  logic [NCH*DIV_W-1:0] note_div,
   output logic [NCH*AUD_W-1:0] audio_ch,
   output logic [AUD_W-1:0]     audio_mix,
   output logic                 env_busy
);
   localparam int PSC_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
   localparam int MIX_W = AUD_W + $clog2(NCH) + 1;
   localparam logic signed [MIX_W-1:0] MAX_S =
      $signed({{(MIX_W-AUD_W+1){1'b0}}, {(AUD_W-1){1'b1}}});
   localparam logic signed [MIX_W-1:0] MIN_S = ~MAX_S;

   logic [PSC_W-1:0]            psc_q, psc_d;
   logic                        tick;
   logic [AUD_W-1:0]            amp;
   logic [NCH-1:0][AUD_W-1:0]   smp;
   logic [NCH-1:0]              busy_vec;
   logic signed [MIX_W-1:0]     sum;
   logic [AUD_W-1:0]            mix_q, mix_d;
   logic                        busy_q;

   // Shared envelope prescaler: one tick every ENV_DIV cycles
   always_comb begin
      tick  = (psc_q == PSC_W'(ENV_DIV - 1));
      psc_d = tick ? '0 : (psc_q + PSC_W'(1));
   end

   // Global volume code to envelope amplitude
   always_comb begin
      amp = '0;
      case (volume)
         2'b01:   amp = AUD_W'(16'h0300);
         2'b11:   amp = AUD_W'(16'h0500);
         2'b10:   amp = AUD_W'(16'h5000);
         default: amp = '0;
      endcase
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      tone_gen_ch #(
         .DIV_W    (DIV_W),
         .AUD_W    (AUD_W),
         .ENV_STEP (ENV_STEP)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .en_i     (ch_en[i]),
         .div_i    (note_div[i*DIV_W +: DIV_W]),
         .tick_i   (tick),
         .amp_i    (amp),
         .sample_o (smp[i]),
         .busy_o   (busy_vec[i])
      );
   end

   // Wide signed sum of all channel samples, clamped to the sample range
   always_comb begin
      sum = '0;
      for (int i = 0; i < NCH; i++) sum = sum + MIX_W'($signed(smp[i]));
      if (sum > MAX_S)      mix_d = MAX_S[AUD_W-1:0];
      else if (sum < MIN_S) mix_d = MIN_S[AUD_W-1:0];
      else                  mix_d = sum[AUD_W-1:0];
   end

   // Prescaler, mix and busy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         psc_q  <= '0;
         mix_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         psc_q  <= psc_d;
         mix_q  <= mix_d;
         busy_q <= |busy_vec;
      end
   end

   assign audio_ch  = smp;
   assign audio_mix = mix_q;
   assign env_busy  = busy_q;
endmodule

// File: tb/tb_tone_gen_mc.sv
// Bench for tone_gen_mc. Two instances: A (fast envelope, square wave and
// mix tests) and B (slow ramp, note change, mute, reset tests). Expected
// values are queued with the cycle they are due; a monitor checks them.

module tb_tone_gen_mc;
   localparam int A_CH0 = 0, A_CH1 = 1, A_MIX = 2, A_BUSY = 3;
   localparam int B_CH0 = 4, B_ABS = 5, B_MIX = 6, B_BUSY = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_a = 1'b1, rst_b = 1'b1;
   logic [1:0]  vol_a = 2'b00, vol_b = 2'b00;
   logic [1:0]  en_a = 2'b00, en_b = 2'b00;
   logic [43:0] div_a = '0, div_b = '0;
   logic [31:0] ach_a, ach_b;
   logic [15:0] mix_a, mix_b;
   logic        busy_a, busy_b;

   tone_gen_mc #(.NCH(2), .DIV_W(22), .AUD_W(16), .ENV_DIV(1), .ENV_STEP(16'h5000)) dut_a (
      .clk(clk), .rst(rst_a), .volume(vol_a), .ch_en(en_a), .note_div(div_a),
      .audio_ch(ach_a), .audio_mix(mix_a), .env_busy(busy_a));

   tone_gen_mc #(.NCH(2), .DIV_W(22), .AUD_W(16), .ENV_DIV(4), .ENV_STEP(16'h0100)) dut_b (
      .clk(clk), .rst(rst_b), .volume(vol_b), .ch_en(en_b), .note_div(div_b),
      .audio_ch(ach_b), .audio_mix(mix_b), .env_busy(busy_b));

   typedef struct {
      int          cyc;
      int          sel;
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic logic [15:0] pick(int sel);
      logic [15:0] v;
      case (sel)
         A_CH0:   v = ach_a[15:0];
         A_CH1:   v = ach_a[31:16];
         A_MIX:   v = mix_a;
         A_BUSY:  v = {15'd0, busy_a};
         B_CH0:   v = ach_b[15:0];
         B_ABS:   v = ach_b[15] ? (16'd0 - ach_b[15:0]) : ach_b[15:0];
         B_MIX:   v = mix_b;
         default: v = {15'd0, busy_b};
      endcase
      return v;
   endfunction

   // Monitor: pops every expectation due at this cycle and compares
   initial begin
      exp_t        e;
      logic [15:0] act;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e   = sbq.pop_front();
            act = pick(e.sel);
            n_chk++;
            if (e.cyc != cyc || act !== e.val) begin
               n_fail++;
               $display("FAIL %s cyc %0d (due %0d): got %h expected %h", e.name, cyc, e.cyc, act, e.val);
            end
         end
      end
   end

   task automatic push(input int c, input int s, input logic [15:0] v, input string n);
      exp_t e;
      e.cyc = c; e.sel = s; e.val = v; e.name = n;
      sbq.push_back(e);
   endtask

   task automatic go(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Reset both DUTs for two edges; every output must be zero right after the first
   task automatic rst_pulse(output int r);
      rst_a = 1'b1; rst_b = 1'b1;
      for (int s = 0; s < 8; s++) if (s != B_ABS) push(cyc + 1, s, 16'h0000, "reset_zero");
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      r = cyc;
   endtask

   initial begin
      int r;
      // A1: square wave, ch0 only, div 3 -> half-period 4
      vol_a = 2'b10; en_a = 2'b01; div_a = {22'd3, 22'd3};
      rst_pulse(r);
      push(r+3,  A_BUSY, 16'h0001, "a_busy_rise");
      push(r+4,  A_CH0,  16'hB000, "a_ch0_first_neg");
      push(r+4,  A_BUSY, 16'h0000, "a_busy_fall");
      push(r+6,  A_CH0,  16'hB000, "a_ch0_neg_end");
      push(r+7,  A_CH0,  16'h5000, "a_ch0_pos");
      push(r+8,  A_CH1,  16'h0000, "a_ch1_off");
      push(r+8,  A_MIX,  16'h5000, "a_mix_single");
      push(r+10, A_CH0,  16'h5000, "a_ch0_pos_end");
      push(r+11, A_CH0,  16'hB000, "a_ch0_neg2");
      push(r+15, A_CH0,  16'h5000, "a_ch0_pos2");
      go(r+16);

      // A2: both channels in phase -> mix saturates both ways
      en_a = 2'b11; div_a = {22'd5, 22'd5};
      rst_pulse(r);
      push(r+6,  A_MIX, 16'h8000, "mix_sat_neg");
      push(r+12, A_MIX, 16'h7FFF, "mix_sat_pos");
      go(r+13);

      // A3: ch1 gets one long half-period, then runs in antiphase
      div_a = {22'd11, 22'd5};
      rst_pulse(r);
      push(r+18, A_CH0, 16'hB000, "anti_ch0");
      push(r+18, A_CH1, 16'h5000, "anti_ch1");
      push(r+18, A_MIX, 16'h0000, "mix_cancel");
      push(r+24, A_MIX, 16'h0000, "mix_cancel2");
      go(r+2);
      div_a = {22'd5, 22'd5};
      go(r+25);

      // B1: ramp up in 3 ticks, hold, then ramp down on volume 00
      vol_b = 2'b01; en_b = 2'b01; div_b = {22'd9, 22'd9};
      rst_pulse(r);
      push(r+4,  B_CH0,  16'h0000, "ramp_start");
      push(r+5,  B_ABS,  16'h0100, "ramp_1");
      push(r+8,  B_ABS,  16'h0100, "ramp_1_hold");
      push(r+9,  B_ABS,  16'h0200, "ramp_2");
      push(r+12, B_BUSY, 16'h0001, "busy_ramp");
      push(r+13, B_ABS,  16'h0300, "ramp_3");
      push(r+13, B_BUSY, 16'h0000, "busy_done");
      push(r+14, B_MIX,  16'h0300, "b_mix");
      push(r+20, B_ABS,  16'h0300, "ramp_hold");
      go(r+20);
      vol_b = 2'b00;
      push(r+21, B_BUSY, 16'h0001, "busy_retarget");
      push(r+25, B_ABS,  16'h0200, "down_1");
      push(r+29, B_ABS,  16'h0100, "down_2");
      push(r+32, B_BUSY, 16'h0001, "busy_down");
      push(r+33, B_CH0,  16'h0000, "down_zero");
      push(r+33, B_BUSY, 16'h0000, "busy_down_done");
      push(r+34, B_CH0,  16'h0000, "no_neg_zero");
      go(r+35);

      // B2: note change mid-period waits for the current half-period
      vol_b = 2'b01; en_b = 2'b01; div_b = {22'd9, 22'd9};
      rst_pulse(r);
      push(r+11, B_CH0, 16'hFE00, "note_old_half");
      push(r+13, B_CH0, 16'h0300, "note_toggle_cnt9");
      push(r+16, B_CH0, 16'h0300, "note_new_half_end");
      push(r+17, B_CH0, 16'hFD00, "note_new_toggle");
      push(r+21, B_CH0, 16'h0300, "note_new_toggle2");
      go(r+4);
      div_b = {22'd9, 22'd3};
      go(r+22);

      // B3: ch_en drop decays envelope while phase runs; then div 1 mutes
      div_b = {22'd9, 22'd9};
      rst_pulse(r);
      push(r+13, B_ABS, 16'h0300, "mute_pre");
      go(r+13);
      en_b = 2'b00;
      push(r+17, B_ABS,  16'h0200, "mute_1");
      push(r+21, B_CH0,  16'h0100, "mute_2_pos");
      push(r+23, B_CH0,  16'hFF00, "mute_phase_runs");
      push(r+25, B_CH0,  16'h0000, "mute_zero");
      go(r+25);
      en_b = 2'b01; div_b = {22'd9, 22'd1};
      push(r+33, B_ABS,  16'h0200, "div1_before_wrap");
      push(r+41, B_CH0,  16'h0000, "div1_zero");
      push(r+45, B_CH0,  16'h0000, "div1_stays_zero");
      push(r+45, B_BUSY, 16'h0000, "div1_idle");
      go(r+46);

      // B4: reset mid-ramp and mid-period, then a fresh ramp
      div_b = {22'd9, 22'd9};
      rst_pulse(r);
      push(r+9, B_ABS, 16'h0200, "pre_reset_ramp");
      go(r+9);
      rst_pulse(r);
      push(r+4, B_CH0, 16'h0000, "fresh_zero");
      push(r+5, B_CH0, 16'hFF00, "fresh_ramp_1");
      push(r+9, B_CH0, 16'hFE00, "fresh_ramp_2");
      go(r+11);

      n_chk++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
